// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
//   Shared types and helpers for the bimodal branch predictor.
//   - bp_ctr_e      : 2-bit saturating direction counter encoding
//   - BP_CTR_ALLOC  : counter value written when a taken branch allocates
//   - bp_index/tag  : PC slicing helpers, parameterised by the index width
// ---------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,   // strongly not taken
        BP_WNT = 2'b01,   // weakly not taken
        BP_WT  = 2'b10,   // weakly taken
        BP_ST  = 2'b11    // strongly taken
    } bp_ctr_e;

    localparam bp_ctr_e BP_CTR_ALLOC = BP_WT;

    // Widest PC the slicing helpers support; callers zero-extend into this
    // width and truncate the result to the field they need.
    localparam int BP_MAX_W = 64;

    // Table index: word-aligned PC bits just above the byte offset.
    function automatic logic [BP_MAX_W-1:0] bp_index(
        input logic [BP_MAX_W-1:0] pc,
        input int                  idx_bits
    );
        bp_index = (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
    endfunction

    // Tag: everything above the index field.
    function automatic logic [BP_MAX_W-1:0] bp_tag(
        input logic [BP_MAX_W-1:0] pc,
        input int                  idx_bits
    );
        bp_tag = pc >> (idx_bits + 2);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
//   Combinational next-state for a 2-bit saturating direction counter.
//   Ports:
//     ctr_i  current counter value
//     inc_i  1 = move toward strongly taken, 0 = toward strongly not taken
//     ctr_o  next counter value (saturates at BP_ST / BP_SNT)
// ---------------------------------------------------------------------------
module sat_counter2
    import branch_pkg::*;
(
    input  bp_ctr_e ctr_i,
    input  logic    inc_i,
    output bp_ctr_e ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != BP_ST) begin
                ctr_o = bp_ctr_e'(ctr_i + 2'd1);
            end
        end else begin
            if (ctr_i != BP_SNT) begin
                ctr_o = bp_ctr_e'(ctr_i - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Bimodal direction predictor with a direct-mapped branch target buffer.
//   Fetch looks up a PC and gets a registered prediction one cycle later;
//   execute trains the table with the resolved direction and target.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     pred_req / pred_pc       fetch lookup request and PC
//     pred_valid/take/target   prediction, valid the cycle after pred_req
//     upd_valid/pc/take/target resolved branch from execute
//     upd_predicted            direction fetch used for that branch
//     clear                    invalidate every entry
//     branch_count             resolved branches seen
//     mispred_count            resolved branches that were mispredicted
// ---------------------------------------------------------------------------
module branch_predictor
    import branch_pkg::*;
#(
    parameter int Width   = 32,
    parameter int Entries = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_req,
    input  logic [Width-1:0] pred_pc,
    output logic             pred_valid,
    output logic             pred_take,
    output logic [Width-1:0] pred_target,
    input  logic             upd_valid,
    input  logic [Width-1:0] upd_pc,
    input  logic             upd_take,
    input  logic [Width-1:0] upd_target,
    input  logic             upd_predicted,
    input  logic             clear,
    output logic [31:0]      branch_count,
    output logic [31:0]      mispred_count
);

    localparam int IdxBits = $clog2(Entries);
    localparam int TagW    = Width - IdxBits - 2;

    // Tag/target/counter storage carries no reset so it can map onto RAM;
    // only the valid vector is reset.
    logic [TagW-1:0]  tag_q    [Entries];
    logic [Width-1:0] target_q [Entries];
    bp_ctr_e          ctr_q    [Entries];
    logic [Entries-1:0] valid_q;
    logic [Entries-1:0] valid_d;

    logic             pred_valid_q;
    logic             pred_take_q,   pred_take_d;
    logic [Width-1:0] pred_target_q, pred_target_d;
    logic [31:0]      branch_cnt_q,  branch_cnt_d;
    logic [31:0]      mispred_cnt_q, mispred_cnt_d;

    logic [IdxBits-1:0] lk_idx, up_idx;
    logic [TagW-1:0]    lk_tag, up_tag;
    logic               lk_hit, up_hit;
    logic               up_write;
    bp_ctr_e            up_ctr_next;

    assign lk_idx = IdxBits'(bp_index(BP_MAX_W'(pred_pc), IdxBits));
    assign lk_tag = TagW'(bp_tag(BP_MAX_W'(pred_pc), IdxBits));
    assign up_idx = IdxBits'(bp_index(BP_MAX_W'(upd_pc), IdxBits));
    assign up_tag = TagW'(bp_tag(BP_MAX_W'(upd_pc), IdxBits));

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // A clear in the same cycle drops the table side of an update; a miss
    // that resolved not-taken leaves the table alone.
    assign up_write = upd_valid && !clear && (up_hit || upd_take);

    sat_counter2 u_ctr_next (
        .ctr_i (ctr_q[up_idx]),
        .inc_i (upd_take),
        .ctr_o (up_ctr_next)
    );

    // Lookup reads the arrays before this edge's update lands, so a
    // same-cycle lookup and update to one index see the old contents.
    always_comb begin
        pred_take_d   = pred_take_q;
        pred_target_d = pred_target_q;
        if (pred_req) begin
            if (lk_hit && ctr_q[lk_idx][1]) begin
                pred_take_d   = 1'b1;
                pred_target_d = target_q[lk_idx];
            end else begin
                pred_take_d   = 1'b0;
                pred_target_d = pred_pc + Width'(4);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (clear) begin
            valid_d = '0;
        end else if (upd_valid && !up_hit && upd_take) begin
            valid_d[up_idx] = 1'b1;
        end
    end

    // Counters always count, even when a clear drops the table update.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (upd_take != upd_predicted) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            pred_valid_q  <= 1'b0;
            pred_take_q   <= 1'b0;
            pred_target_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            pred_valid_q  <= pred_req;
            pred_take_q   <= pred_take_d;
            pred_target_q <= pred_target_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (up_write) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr_next;
                if (upd_take) begin
                    target_q[up_idx] <= upd_target;
                end
            end else begin
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= BP_CTR_ALLOC;
            end
        end
    end

    assign pred_valid    = pred_valid_q;
    assign pred_take     = pred_take_q;
    assign pred_target   = pred_target_q;
    assign branch_count  = branch_cnt_q;
    assign mispred_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//   Directed vector table for branch_predictor (Width=32, Entries=64), plus
//   hand-written reset-state and mid-stream reset sequences.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        pred_take;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_take;
    logic [31:0] upd_target;
    logic        upd_predicted;
    logic        clear;
    logic [31:0] branch_count;
    logic [31:0] mispred_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.Width(32), .Entries(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_req      (pred_req),
        .pred_pc       (pred_pc),
        .pred_valid    (pred_valid),
        .pred_take     (pred_take),
        .pred_target   (pred_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_take      (upd_take),
        .upd_target    (upd_target),
        .upd_predicted (upd_predicted),
        .clear         (clear),
        .branch_count  (branch_count),
        .mispred_count (mispred_count)
    );

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        upd;
        logic [31:0] upc;
        logic        utake;
        logic [31:0] utgt;
        logic        upred;
        logic        clr;
        logic        e_take;
        logic [31:0] e_tgt;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    localparam int NV = 33;
    vec_t vt [NV];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic req, input logic [31:0] pc,
                                input logic upd, input logic [31:0] upc,
                                input logic utake, input logic [31:0] utgt,
                                input logic upred, input logic clr,
                                input logic e_take, input logic [31:0] e_tgt,
                                input logic [31:0] e_bc, input logic [31:0] e_mc);
        vec_t v;
        v.req = req; v.pc = pc; v.upd = upd; v.upc = upc; v.utake = utake;
        v.utgt = utgt; v.upred = upred; v.clr = clr; v.e_take = e_take;
        v.e_tgt = e_tgt; v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic idle_inputs();
        pred_req = 0; pred_pc = '0; upd_valid = 0; upd_pc = '0; upd_take = 0;
        upd_target = '0; upd_predicted = 0; clear = 0;
    endtask

    initial begin
        //             req pc      upd upc     ut utgt    up clr  e_take e_tgt  bc  mc
        vt[0]  = mk(1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 0,   0, 32'h104, 0, 0);   // cold lookup
        vt[1]  = mk(0, 32'h0,   1, 32'h100, 1, 32'h80, 0, 0,   0, 32'h104, 1, 1);   // alloc, outputs hold
        vt[2]  = mk(1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 0,   1, 32'h80,  1, 1);   // ctr 10 -> taken
        vt[3]  = mk(1, 32'h100, 1, 32'h100, 0, 32'h0,  1, 0,   1, 32'h80,  2, 2);   // read-before-write, 10->01
        vt[4]  = mk(1, 32'h100, 1, 32'h100, 0, 32'h0,  0, 0,   0, 32'h104, 3, 2);   // sees 01, ->00
        vt[5]  = mk(1, 32'h100, 1, 32'h100, 0, 32'h0,  0, 0,   0, 32'h104, 4, 2);   // 00 stays 00
        vt[6]  = mk(1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 0,   0, 32'h104, 4, 2);
        vt[7]  = mk(0, 32'h0,   1, 32'h100, 1, 32'h90, 0, 0,   0, 32'h104, 5, 3);   // 00->01, target 0x90
        vt[8]  = mk(1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 0,   0, 32'h104, 5, 3);   // 01 not taken
        vt[9]  = mk(0, 32'h0,   1, 32'h100, 1, 32'h94, 0, 0,   0, 32'h104, 6, 4);   // 01->10, target 0x94
        vt[10] = mk(1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 0,   1, 32'h94,  6, 4);
        vt[11] = mk(0, 32'h0,   1, 32'h100, 1, 32'h94, 1, 0,   1, 32'h94,  7, 4);   // 10->11
        vt[12] = mk(0, 32'h0,   1, 32'h100, 1, 32'h94, 1, 0,   1, 32'h94,  8, 4);   // 11 stays
        vt[13] = mk(0, 32'h0,   1, 32'h100, 0, 32'h0,  1, 0,   1, 32'h94,  9, 5);   // 11->10
        vt[14] = mk(0, 32'h0,   1, 32'h100, 0, 32'h0,  1, 0,   1, 32'h94, 10, 6);   // 10->01
        vt[15] = mk(1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 0,   0, 32'h104,10, 6);
        vt[16] = mk(0, 32'h0,   1, 32'h100, 1, 32'h80, 0, 0,   0, 32'h104,11, 7);   // 01->10, target 0x80
        vt[17] = mk(1, 32'h200, 0, 32'h0,   0, 32'h0,  0, 0,   0, 32'h204,11, 7);   // alias tag miss
        vt[18] = mk(0, 32'h0,   1, 32'h200, 1, 32'hA0, 0, 0,   0, 32'h204,12, 8);   // alias replaces
        vt[19] = mk(1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 0,   0, 32'h104,12, 8);   // original misses
        vt[20] = mk(1, 32'h200, 0, 32'h0,   0, 32'h0,  0, 0,   1, 32'hA0, 12, 8);
        vt[21] = mk(0, 32'h0,   1, 32'h300, 0, 32'h0,  0, 0,   1, 32'hA0, 13, 8);   // miss NT: no change
        vt[22] = mk(1, 32'h300, 0, 32'h0,   0, 32'h0,  0, 0,   0, 32'h304,13, 8);
        vt[23] = mk(1, 32'h200, 0, 32'h0,   0, 32'h0,  0, 0,   1, 32'hA0, 13, 8);   // entry untouched
        vt[24] = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 1,   1, 32'hA0, 13, 8);   // clear
        vt[25] = mk(1, 32'h200, 0, 32'h0,   0, 32'h0,  0, 0,   0, 32'h204,13, 8);
        vt[26] = mk(1, 32'h200, 1, 32'h200, 1, 32'hB0, 0, 0,   0, 32'h204,14, 9);   // same-cycle empty
        vt[27] = mk(1, 32'h200, 0, 32'h0,   0, 32'h0,  0, 0,   1, 32'hB0, 14, 9);
        vt[28] = mk(1, 32'h200, 1, 32'h100, 1, 32'hC0, 0, 1,   1, 32'hB0, 15, 10);  // clear wins, lookup pre-clear
        vt[29] = mk(1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 0,   0, 32'h104,15, 10);
        vt[30] = mk(1, 32'h200, 0, 32'h0,   0, 32'h0,  0, 0,   0, 32'h204,15, 10);
        vt[31] = mk(0, 32'h0,   1, 32'h200, 1, 32'hD0, 0, 0,   0, 32'h204,16, 11);
        vt[32] = mk(1, 32'h200, 0, 32'h0,   0, 32'h0,  0, 0,   1, 32'hD0, 16, 11);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk32("reset pred_valid",    32'(pred_valid),  32'd0);
        chk32("reset pred_take",     32'(pred_take),   32'd0);
        chk32("reset pred_target",   pred_target,      32'd0);
        chk32("reset branch_count",  branch_count,     32'd0);
        chk32("reset mispred_count", mispred_count,    32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            pred_req = vt[i].req;  pred_pc = vt[i].pc;
            upd_valid = vt[i].upd; upd_pc = vt[i].upc; upd_take = vt[i].utake;
            upd_target = vt[i].utgt; upd_predicted = vt[i].upred; clear = vt[i].clr;
            @(posedge clk);
            #1;
            chk32($sformatf("v%0d pred_valid", i),   32'(pred_valid), 32'(vt[i].req));
            chk32($sformatf("v%0d pred_take", i),    32'(pred_take),  32'(vt[i].e_take));
            chk32($sformatf("v%0d pred_target", i),  pred_target,     vt[i].e_tgt);
            chk32($sformatf("v%0d branch_count", i), branch_count,    vt[i].e_bc);
            chk32($sformatf("v%0d mispred_count", i),mispred_count,   vt[i].e_mc);
        end

        // Mid-stream asynchronous reset: outputs must drop without a clock edge.
        @(negedge clk);
        pred_req = 1'b1; pred_pc = 32'h200;
        upd_valid = 1'b0; clear = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk32("async rst pred_valid",    32'(pred_valid), 32'd0);
        chk32("async rst pred_take",     32'(pred_take),  32'd0);
        chk32("async rst pred_target",   pred_target,     32'd0);
        chk32("async rst branch_count",  branch_count,    32'd0);
        chk32("async rst mispred_count", mispred_count,   32'd0);
        @(negedge clk);
        rst = 1'b0;
        pred_req = 1'b1; pred_pc = 32'h200;
        @(posedge clk);
        #1;
        chk32("post rst pred_valid",  32'(pred_valid), 32'd1);
        chk32("post rst pred_take",   32'(pred_take),  32'd0);
        chk32("post rst pred_target", pred_target,     32'h204);
        @(negedge clk);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
